word_mem_sequencer: RTL and testbench

- Sits directly upstream of the byte-wide data memory (8-bit address, 8-bit data, combinational read, write on rising clk).
- Accepts 32-bit load/store requests from the datapath and serialises each into four byte accesses, little-endian: byte 0 at the base address.
- Assembles load data into a 32-bit word, reports completion with a one-cycle response pulse, and rejects misaligned addresses.

---
 rtl/word_mem_sequencer.sv | 78 +++++++
 tb/tb_word_mem_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/word_mem_sequencer.sv
// rtl/word_mem_sequencer.sv - serialises 32-bit load/store requests into little-endian byte accesses
module word_mem_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       wdata_q;
  logic              is_write;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      base_addr <= '0;
      wdata_q   <= '0;
      is_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Misaligned requests never touch the address/data registers.
            if (req_addr[1:0] == 2'b00) begin
              base_addr <= req_addr;
              wdata_q   <= req_wdata;
              is_write  <= req_write;
              cnt       <= '0;
              state     <= XFER;
            end else begin
              state <= ERR;
            end
          end
        end
        XFER: begin
          if (!is_write) rdata_q[8*cnt +: 8] <= mem_rdata;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == DONE) || (state == ERR);
  assign misalign_err = (state == ERR);
  assign resp_rdata   = rdata_q;
  assign mem_write    = (state == XFER) && is_write;
  assign mem_addr     = (state == XFER) ? base_addr + {{(ADDR_W-CNT_W){1'b0}}, cnt} : base_addr;
  assign mem_wdata    = mem_write ? wdata_q[8*cnt +: 8] : 8'h00;

endmodule

// File: tb/tb_word_mem_sequencer.sv
// tb/tb_word_mem_sequencer.sv - self-checking bench for word_mem_sequencer with a byte-array reference
module tb_word_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  word_mem_sequencer #(.ADDR_W(8), .WORD_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory driven by the DUT, and the bench's own expected image.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       load_mem;
  int         n_accept = 0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (!rst && req_valid && req_ready) n_accept <= n_accept + 1;
  end

  assign mem_rdata = mem[mem_addr];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic [7:0]  exp_base = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Checks every cycle after the accept edge up to the return of req_ready.
  task automatic follow(input logic w, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] word;
    if (a[1:0] != 2'b00) begin
      @(negedge clk);
      check("err_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("err_misalign", {31'b0, misalign_err}, 32'd1);
      check("err_mem_write", {31'b0, mem_write}, 32'd0);
      check("err_mem_addr", {24'b0, mem_addr}, {24'b0, exp_base});
      check("err_rdata_held", resp_rdata, exp_rdata);
      check("err_not_ready", {31'b0, req_ready}, 32'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("xfer_mem_write", {31'b0, mem_write}, {31'b0, w});
        check("xfer_mem_addr", {24'b0, mem_addr}, {24'b0, 8'(a + k)});
        if (w) check("xfer_mem_wdata", {24'b0, mem_wdata}, {24'b0, d[8*k +: 8]});
        check("xfer_no_resp", {31'b0, resp_valid}, 32'd0);
        check("xfer_not_ready", {31'b0, req_ready}, 32'd0);
      end
      word = {ref_mem[8'(a+3)], ref_mem[8'(a+2)], ref_mem[8'(a+1)], ref_mem[a]};
      if (w) begin
        for (int k = 0; k < 4; k++) ref_mem[8'(a + k)] = d[8*k +: 8];
      end else begin
        exp_rdata = word;
      end
      exp_base = a;
      @(negedge clk);
      check("done_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("done_misalign", {31'b0, misalign_err}, 32'd0);
      check("done_mem_write", {31'b0, mem_write}, 32'd0);
      check("done_rdata", resp_rdata, exp_rdata);
    end
    @(negedge clk);
    check("ready_back", {31'b0, req_ready}, 32'd1);
    check("resp_cleared", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic op(input logic w, input logic [7:0] a, input logic [31:0] d);
    issue(w, a, d);
    follow(w, a, d);
  endtask

  initial begin
    int acc0;
    int diffs;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    rst = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; load_mem = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);

    op(1'b1, 8'h10, 32'hDEADBEEF);
    op(1'b0, 8'h10, 32'h0);
    check("t2_load_value", resp_rdata, 32'hDEADBEEF);
    op(1'b0, 8'h0E, 32'h0);
    op(1'b1, 8'hFC, 32'h11223344);
    op(1'b0, 8'hFC, 32'h0);
    check("t4_no_wrap_load", resp_rdata, 32'h11223344);

    // Reset lands on the edge that writes the second byte.
    issue(1'b1, 8'h20, 32'hAABBCCDD);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ref_mem[8'h20] = 8'hDD; ref_mem[8'h21] = 8'hCC;
    exp_rdata = 32'h0; exp_base = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_resp", {31'b0, resp_valid}, 32'd0);
      check("t5_no_write", {31'b0, mem_write}, 32'd0);
    end
    check("t5_ready", {31'b0, req_ready}, 32'd1);
    check("t5_rdata", resp_rdata, 32'd0);
    check("t5_mem20", {24'b0, mem[8'h20]}, 32'hDD);
    check("t5_mem21", {24'b0, mem[8'h21]}, 32'hCC);
    check("t5_mem22", {24'b0, mem[8'h22]}, {24'b0, ref_mem[8'h22]});
    check("t5_mem23", {24'b0, mem[8'h23]}, {24'b0, ref_mem[8'h23]});

    // Request coinciding with reset is dropped.
    acc0 = n_accept;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 32'h55555555;
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_req_dropped_ready", {31'b0, req_ready}, 32'd1);
    check("rst_req_dropped_write", {31'b0, mem_write}, 32'd0);
    check("rst_req_dropped_count", n_accept, acc0);

    // Held request during a store, then back-to-back load.
    acc0 = n_accept;
    issue(1'b1, 8'h40, 32'hCAFEF00D);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    follow(1'b1, 8'h40, 32'hCAFEF00D);
    @(posedge clk);
    #1 req_valid = 1'b0;
    follow(1'b0, 8'h40, 32'h0);
    check("t6_load_value", resp_rdata, 32'hCAFEF00D);
    check("t6_accept_once", n_accept, acc0 + 2);

    for (int i = 0; i < 30; i++) begin
      a = 8'h40 + 8'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a | 8'($urandom_range(1, 3));
      op(1'($urandom), a, $urandom);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("final_mem_image_diffs", diffs, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
